esc_arm_ctrl: RTL and testbench
===============================

// Module: esc_arm_ctrl
// PURPOSE
//   Sequencer in front of one esc PWM channel: arms the ESC with a held
//   zero-throttle period, slew-limits throttle increases, and forces zero
//   throttle on kill, disarm or command watchdog timeout. Sits between the
//   flight-control command source and esc.cmd; runs on the 1 MHz domain.
// PARAMETERS
//   CLK_PER_MS  1000  clk_1M cycles per 1 ms tick
//   ARM_MS      2000  ms of zero throttle held before RUN
//   WDOG_MS     100   ms without cmd_valid in RUN before FAULT
//   STEP        8     max cmd_out increase per ms tick (LSB)
// PORTS
//   clk_1M     in   1   1 MHz system clock
//   rst_n      in   1   asynchronous reset, active-low
//   arm        in   1   level: request armed operation
//   kill       in   1   level: emergency stop, highest priority
//   cmd_valid  in   1   1-cycle strobe, cmd_in is a new throttle target
//   cmd_in     in   10  throttle target, 0..1023
//   cmd_out    out  10  throttle to esc.cmd, registered
//   armed      out  1   1 while state==RUN
//   fault      out  1   1 while state==FAULT
//   state      out  2   IDLE=0, ARMING=1, RUN=2, FAULT=3
// BEHAVIOUR
//   Reset: state=IDLE, cmd_out=0, armed=0, fault=0, target=0, all counters 0.
//   Tick: free-running prescaler 0..CLK_PER_MS-1; tick=1 in the cycle it
//     equals CLK_PER_MS-1, then wraps to 0. Not cleared by state changes.
//   Priority each cycle: kill > arm==0 > watchdog expiry > normal operation.
//   IDLE: cmd_out=0. arm=1 & kill=0 -> ARMING; arm_cnt=0.
//   ARMING: cmd_out=0. arm_cnt++ on tick; arm_cnt==ARM_MS -> RUN with
//     target=0, wdog_cnt=0. kill -> FAULT. arm=0 -> IDLE.
//   RUN: cmd_valid latches target=cmd_in and clears wdog_cnt (same cycle).
//     On tick: if target>cmd_out, cmd_out += min(STEP, target-cmd_out);
//     wdog_cnt++ (saturating at WDOG_MS). If target<cmd_out, cmd_out=target
//     on the next clock, no tick needed. Ramp uses target as registered
//     before this cycle (cmd_valid coincident with tick applies next tick).
//     wdog_cnt==WDOG_MS -> FAULT. arm=0 -> IDLE. kill -> FAULT.
//   FAULT: cmd_out=0, fault=1. Leave only when arm=0 & kill=0 -> IDLE;
//     holding arm=1 keeps FAULT (operator must cycle arm to re-arm).
//   Any exit from RUN: cmd_out=0 on the next clock edge (1-cycle latency).
//   Outputs registered; armed/fault/state change on the same edge as state.
//   Arithmetic: 10-bit unsigned; ramp result never exceeds target, no wrap.
//   cmd_valid ignored outside RUN; target reset to 0 on each RUN entry.
//   Async reset mid-RUN: cmd_out drops to 0 immediately, state=IDLE.
// TESTING (bench uses CLK_PER_MS=10, ARM_MS=5, WDOG_MS=20, STEP=8)
//   Arm: release rst_n, arm=1 -> state=1 for 5 ticks (~50 cycles), then
//     state=2, armed=1, cmd_out=0 throughout.
//   Ramp: in RUN, cmd_valid with cmd_in=1023, refreshed every 10 ticks ->
//     cmd_out 8,16,24..1016,1023 on successive ticks; never exceeds 1023.
//   Step-down: at cmd_out=512, cmd_valid cmd_in=12 -> cmd_out=12 on next
//     clock; then cmd_in=0 -> cmd_out=0 next clock.
//   Watchdog: in RUN, stop cmd_valid -> after 20 ticks state=3, fault=1,
//     cmd_out=0; arm held 1 -> stays FAULT; arm=0 -> IDLE next clock.
//   Kill: in RUN at cmd_out=300, kill=1 -> state=3, cmd_out=0 next clock;
//     kill during ARMING -> FAULT; arm drop during ARMING -> IDLE.
//   Reset mid-RUN: rst_n=0 at cmd_out=500 -> cmd_out=0, state=0
//     immediately (asynchronously), before next clk_1M edge.

Source files
------------

// File: rtl/esc_arm_ctrl.sv
// ESC arming sequencer for a single PWM channel: holds zero throttle while
// arming, slew-limits throttle rises, and forces zero throttle on kill,
// disarm or loss of commands.
module esc_arm_ctrl #(
    parameter int unsigned CLK_PER_MS = 1000,
    parameter int unsigned ARM_MS     = 2000,
    parameter int unsigned WDOG_MS    = 100,
    parameter int unsigned STEP       = 8
) (
    input  logic       clk_1M,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       kill,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_in,
    output logic [9:0] cmd_out,
    output logic       armed,
    output logic       fault,
    output logic [1:0] state
);

    localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int unsigned AW = $clog2(ARM_MS + 1);
    localparam int unsigned WW = $clog2(WDOG_MS + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);
    localparam logic [AW-1:0] ARM_END   = AW'(ARM_MS);
    localparam logic [WW-1:0] WDOG_END  = WW'(WDOG_MS);
    localparam logic [9:0]    STEP_V    = 10'(STEP);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArming = 2'd1,
        StRun    = 2'd2,
        StFault  = 2'd3
    } state_t;

    state_t        st;
    logic [PW-1:0] presc;
    logic          tick;
    logic [AW-1:0] arm_cnt;
    logic [WW-1:0] wdog_cnt;
    logic [9:0]    target;
    logic [9:0]    diff;
    logic [9:0]    ramp_inc;

    assign tick  = (presc == PRESC_MAX);
    assign state = st;

    // Ramp increment: remaining distance to target, capped at STEP, so the
    // sum can never pass the target or wrap.
    assign diff     = target - cmd_out;
    assign ramp_inc = (diff < STEP_V) ? diff : STEP_V;

    // Free-running 1 ms prescaler, independent of FSM state.
    always_ff @(posedge clk_1M or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Sequencer FSM with registered throttle, armed and fault outputs.
    always_ff @(posedge clk_1M or negedge rst_n) begin
        if (!rst_n) begin
            st       <= StIdle;
            cmd_out  <= '0;
            armed    <= 1'b0;
            fault    <= 1'b0;
            target   <= '0;
            arm_cnt  <= '0;
            wdog_cnt <= '0;
        end else begin
            unique case (st)
                StIdle: begin
                    cmd_out <= '0;
                    if (arm && !kill) begin
                        st      <= StArming;
                        arm_cnt <= '0;
                    end
                end
                StArming: begin
                    cmd_out <= '0;
                    if (kill) begin
                        st    <= StFault;
                        fault <= 1'b1;
                    end else if (!arm) begin
                        st <= StIdle;
                    end else if (arm_cnt == ARM_END) begin
                        st       <= StRun;
                        armed    <= 1'b1;
                        target   <= '0;
                        wdog_cnt <= '0;
                    end else if (tick) begin
                        arm_cnt <= arm_cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (kill || (arm && wdog_cnt == WDOG_END)) begin
                        st      <= StFault;
                        armed   <= 1'b0;
                        fault   <= 1'b1;
                        cmd_out <= '0;
                    end else if (!arm) begin
                        st      <= StIdle;
                        armed   <= 1'b0;
                        cmd_out <= '0;
                    end else begin
                        // A strobe clears the watchdog even on a tick cycle.
                        if (cmd_valid) begin
                            target   <= cmd_in;
                            wdog_cnt <= '0;
                        end else if (tick) begin
                            wdog_cnt <= wdog_cnt + 1'b1;
                        end
                        // Uses the target registered before this cycle.
                        if (target < cmd_out) begin
                            cmd_out <= target;
                        end else if (tick && target > cmd_out) begin
                            cmd_out <= cmd_out + ramp_inc;
                        end
                    end
                end
                StFault: begin
                    cmd_out <= '0;
                    if (!arm && !kill) begin
                        st    <= StIdle;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    st      <= StIdle;
                    cmd_out <= '0;
                    armed   <= 1'b0;
                    fault   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esc_arm_ctrl.sv
// Directed, self-checking bench for esc_arm_ctrl with short timing constants.
module tb_esc_arm_ctrl;

    localparam int unsigned CLK_PER_MS = 10;
    localparam int unsigned ARM_MS     = 5;
    localparam int unsigned WDOG_MS    = 20;
    localparam int unsigned STEP       = 8;

    logic       clk_1M = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       kill = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_in = '0;
    logic [9:0] cmd_out;
    logic       armed;
    logic       fault;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;       // clock edges since the last reset release
    int m_target = 0;  // reference throttle target
    int m_out = 0;     // reference throttle output

    typedef struct {
        logic       arm;
        logic       kill;
        logic       cmd_valid;
        logic [9:0] cmd_in;
        logic [1:0] st;
        logic [9:0] out;
    } vec_t;

    vec_t vecs[12];

    esc_arm_ctrl #(
        .CLK_PER_MS(CLK_PER_MS),
        .ARM_MS    (ARM_MS),
        .WDOG_MS   (WDOG_MS),
        .STEP      (STEP)
    ) dut (
        .clk_1M   (clk_1M),
        .rst_n    (rst_n),
        .arm      (arm),
        .kill     (kill),
        .cmd_valid(cmd_valid),
        .cmd_in   (cmd_in),
        .cmd_out  (cmd_out),
        .armed    (armed),
        .fault    (fault),
        .state    (state)
    );

    always #5 clk_1M = ~clk_1M;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_st(input string name, input int st, input int out);
        check({name, " state"}, int'(state), st);
        check({name, " cmd_out"}, int'(cmd_out), out);
        check({name, " armed"}, int'(armed), (st == 2) ? 1 : 0);
        check({name, " fault"}, int'(fault), (st == 3) ? 1 : 0);
    endtask

    // Inputs and checks happen 1 time unit after the rising edge.
    task automatic clk_step();
        @(posedge clk_1M);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input logic arm_v);
        rst_n = 1'b0;
        arm = arm_v;
        kill = 1'b0;
        cmd_valid = 1'b0;
        cmd_in = '0;
        clk_step();
        clk_step();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One edge in RUN, compared against the reference ramp model.
    task automatic run_edge();
        int tq;
        int d;
        tq = m_target;
        if (cmd_valid) m_target = int'(cmd_in);
        clk_step();
        if (tq < m_out) begin
            m_out = tq;
        end else if ((cyc % CLK_PER_MS) == 0 && tq > m_out) begin
            d = tq - m_out;
            m_out = m_out + ((d < STEP) ? d : STEP);
        end
        check_st("run", 2, m_out);
    endtask

    task automatic strobe(input int v);
        cmd_valid = 1'b1;
        cmd_in = 10'(v);
        run_edge();
        cmd_valid = 1'b0;
    endtask

    // Runs n edges, refreshing the target every 10 ms to keep the watchdog fed.
    task automatic run_for(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            if (((cyc + 1) % 100) == 55) begin
                cmd_valid = 1'b1;
                cmd_in = 10'(v);
            end
            run_edge();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_run(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            clk_step();
            if (state == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " reach RUN"}, int'(ok), 1);
        m_target = 0;
        m_out = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout at edge %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int t_last;

        //        arm   kill  cv    cmd_in  st    out
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 10'd0,   2'd0, 10'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 10'd0,   2'd0, 10'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 10'd0,   2'd0, 10'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 10'd0,   2'd1, 10'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 10'd500, 2'd1, 10'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 10'd0,   2'd0, 10'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 10'd0,   2'd1, 10'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 10'd0,   2'd3, 10'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 10'd0,   2'd3, 10'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 10'd0,   2'd3, 10'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 10'd0,   2'd0, 10'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 10'd0,   2'd1, 10'd0};

        // Reset state and single-edge FSM transitions.
        do_reset(1'b0);
        check_st("reset", 0, 0);
        for (int i = 0; i < 12; i++) begin
            arm = vecs[i].arm;
            kill = vecs[i].kill;
            cmd_valid = vecs[i].cmd_valid;
            cmd_in = vecs[i].cmd_in;
            clk_step();
            check_st($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].out));
        end
        cmd_valid = 1'b0;

        // Arming: IDLE at edge 1 -> ARMING, ticks at edges 10..50, RUN at 51.
        do_reset(1'b1);
        check_st("post_reset", 0, 0);
        for (int i = 1; i <= 50; i++) begin
            clk_step();
            check_st("arming", 1, 0);
        end
        clk_step();
        check_st("run_entry", 2, 0);
        m_target = 0;
        m_out = 0;

        // Full-scale ramp, last step clipped to 1023.
        strobe(1023);
        run_for(1300, 1023);
        check("ramp_final", int'(cmd_out), 1023);

        // Step-down needs no tick.
        strobe(512);
        run_edge();
        check("stepdown_512", int'(cmd_out), 512);
        strobe(12);
        run_edge();
        check("stepdown_12", int'(cmd_out), 12);
        strobe(0);
        run_edge();
        check("stepdown_0", int'(cmd_out), 0);

        // Kill while running at 300.
        strobe(300);
        run_for(400, 300);
        check("ramp_300", int'(cmd_out), 300);
        kill = 1'b1;
        clk_step();
        check_st("kill_run", 3, 0);
        kill = 1'b0;
        clk_step();
        check_st("fault_hold_kill", 3, 0);
        arm = 1'b0;
        clk_step();
        check_st("fault_exit_kill", 0, 0);

        // Watchdog: 20 ticks after the last strobe, then FAULT on the next edge.
        arm = 1'b1;
        wait_run("wdog");
        strobe(40);
        k = cyc;
        t_last = ((k / CLK_PER_MS) + 1) * CLK_PER_MS + (WDOG_MS - 1) * CLK_PER_MS;
        while (cyc < t_last) run_edge();
        check("wdog_ramp", int'(cmd_out), 40);
        clk_step();
        check_st("wdog_fault", 3, 0);
        clk_step();
        check_st("wdog_arm_held", 3, 0);
        arm = 1'b0;
        clk_step();
        check_st("wdog_disarm", 0, 0);

        // Async reset mid-RUN drops outputs before the next clock edge.
        arm = 1'b1;
        wait_run("rst");
        strobe(500);
        run_for(700, 500);
        check("ramp_500", int'(cmd_out), 500);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst state", int'(state), 0);
        check("async_rst cmd_out", int'(cmd_out), 0);
        check("async_rst armed", int'(armed), 0);
        arm = 1'b0;
        clk_step();
        rst_n = 1'b1;
        cyc = 0;
        clk_step();
        check_st("after_rst", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
